// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file and its clear sequencer.
package regfile_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_e;

    // Register-index width for a given register count.
    function automatic int idx_width(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: walks entries 1..NREGS-1 writing zero after reset or on request.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int AW    = idx_width(NREGS)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clear,
    output logic          o_busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_idx
);

    localparam logic [AW-1:0] FIRST_IDX = AW'(1);
    localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);

    clr_state_e    state_reg;
    clr_state_e    state_next;
    logic [AW-1:0] cnt_reg;
    logic [AW-1:0] cnt_next;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= CLEAR;
            cnt_reg   <= FIRST_IDX;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            CLEAR: begin
                // Exit is decided on the last index, so the counter never wraps.
                if (cnt_reg == LAST_IDX) begin
                    state_next = READY;
                    cnt_next   = FIRST_IDX;
                end else begin
                    cnt_next = cnt_reg + AW'(1);
                end
            end
            READY: begin
                if (i_clear) begin
                    state_next = CLEAR;
                    cnt_next   = FIRST_IDX;
                end
            end
            default: begin
                state_next = CLEAR;
                cnt_next   = FIRST_IDX;
            end
        endcase
    end

    assign o_busy  = (state_reg == CLEAR);
    assign clr_we  = (state_reg == CLEAR);
    assign clr_idx = cnt_reg;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port integer register file with x0 hardwired to zero, optional write bypass and hardware clear.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 0,
    parameter int AW     = idx_width(NREGS)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NRD*AW-1:0]   i_rnum,
    output logic [NRD*XLEN-1:0] o_rd,
    input  logic [NWR-1:0]      i_wen,
    input  logic [NWR*AW-1:0]   i_wnum,
    input  logic [NWR*XLEN-1:0] i_wd,
    input  logic                i_clear,
    output logic                o_busy
);

    logic            busy;
    logic            clr_we;
    logic [AW-1:0]   clr_idx;

    logic [NWR-1:0]  wr_en;
    logic [AW-1:0]   wr_idx  [NWR];
    logic [XLEN-1:0] wr_data [NWR];

    // Entry 0 has no storage; it is the constant zero register.
    logic [XLEN-1:0] regs_reg [1:NREGS-1];

    regfile_clear_fsm #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clear_fsm (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (i_clear),
        .o_busy  (busy),
        .clr_we  (clr_we),
        .clr_idx (clr_idx)
    );

    assign o_busy = busy;

    for (genvar gi = 0; gi < NWR; gi++) begin : g_wr
        assign wr_idx[gi]  = i_wnum[gi*AW +: AW];
        assign wr_data[gi] = i_wd[gi*XLEN +: XLEN];
        assign wr_en[gi]   = i_wen[gi] && (i_wnum[gi*AW +: AW] != '0);
    end

    // Clear owns the array while busy; otherwise later ports overwrite earlier ones.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (clr_we) begin
                regs_reg[clr_idx] <= '0;
            end else begin
                for (int k = 0; k < NWR; k++) begin
                    if (wr_en[k]) begin
                        regs_reg[wr_idx[k]] <= wr_data[k];
                    end
                end
            end
        end
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0]   rnum;
        logic [XLEN-1:0] rd_val;

        assign rnum = i_rnum[gi*AW +: AW];

        always_comb begin
            rd_val = '0;
            if (!busy && (rnum != '0)) begin
                rd_val = regs_reg[rnum];
                // wr_en already excludes index 0, so a match implies a real register.
                if (BYPASS != 0) begin
                    for (int k = 0; k < NWR; k++) begin
                        if (wr_en[k] && (wr_idx[k] == rnum)) begin
                            rd_val = wr_data[k];
                        end
                    end
                end
            end
        end

        assign o_rd[gi*XLEN +: XLEN] = rd_val;
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: directed clear/reset sequences, a write/read vector table and randomized multi-port traffic.
module tb_register_file_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: NREGS=32, NRD=2, NWR=1, no bypass
    logic        a_rst, a_clear, a_busy;
    logic [9:0]  a_rnum;
    logic [63:0] a_rd;
    logic [0:0]  a_wen;
    logic [4:0]  a_wnum;
    logic [31:0] a_wd;

    // Instances B (bypass) and C (no bypass): NREGS=16, NRD=4, NWR=2, shared stimulus
    logic         bc_rst, bc_clear, b_busy, c_busy;
    logic [15:0]  bc_rnum;
    logic [127:0] b_rd, c_rd;
    logic [1:0]   bc_wen;
    logic [7:0]   bc_wnum;
    logic [63:0]  bc_wd;

    int n_checks = 0;
    int n_fail   = 0;

    register_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(1), .BYPASS(0)) dut_a (
        .i_clk(clk), .i_rst(a_rst), .i_rnum(a_rnum), .o_rd(a_rd), .i_wen(a_wen),
        .i_wnum(a_wnum), .i_wd(a_wd), .i_clear(a_clear), .o_busy(a_busy)
    );

    register_file_mp #(.XLEN(32), .NREGS(16), .NRD(4), .NWR(2), .BYPASS(1)) dut_b (
        .i_clk(clk), .i_rst(bc_rst), .i_rnum(bc_rnum), .o_rd(b_rd), .i_wen(bc_wen),
        .i_wnum(bc_wnum), .i_wd(bc_wd), .i_clear(bc_clear), .o_busy(b_busy)
    );

    register_file_mp #(.XLEN(32), .NREGS(16), .NRD(4), .NWR(2), .BYPASS(0)) dut_c (
        .i_clk(clk), .i_rst(bc_rst), .i_rnum(bc_rnum), .o_rd(c_rd), .i_wen(bc_wen),
        .i_wnum(bc_wnum), .i_wd(bc_wd), .i_clear(bc_clear), .o_busy(c_busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts busy cycles on A, checking reads are zero throughout; i_clear pulsed in [clr_on, clr_off).
    task automatic run_clear_a(input string nm, input int exp_len, input int clr_on, input int clr_off);
        int cycles;
        cycles = 0;
        while (a_busy === 1'b1 && cycles < 200) begin
            a_rnum  = 10'($urandom);
            a_clear = (cycles >= clr_on && cycles < clr_off);
            #1;
            chk({nm, "_rd0"}, a_rd[31:0], 64'd0);
            chk({nm, "_rd1"}, a_rd[63:32], 64'd0);
            tick();
            cycles++;
        end
        a_clear = 1'b0;
        chk({nm, "_len"}, 64'(cycles), 64'(exp_len));
        $display("clear sequence %s: busy for %0d cycles", nm, cycles);
    endtask

    task automatic check_all_zero_a(input string nm);
        a_wen = 1'b0;
        for (int i = 0; i < 32; i++) begin
            a_rnum = {5'(31 - i), 5'(i)};
            #1;
            chk({nm, "_p0"}, a_rd[31:0], 64'd0);
            chk({nm, "_p1"}, a_rd[63:32], 64'd0);
        end
    endtask

    typedef struct {
        logic        wen;
        logic [4:0]  wnum;
        logic [31:0] wd;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t tbl[8];

    logic [31:0] mem [16];
    logic [3:0]  rn  [4];
    logic [3:0]  wn0, wn1;
    logic [31:0] exp_b, exp_c;
    int          busy_left, cycles, s;

    initial begin
        a_rst = 1'b1; a_clear = 1'b0; a_rnum = '0; a_wen = '0; a_wnum = '0; a_wd = '0;
        bc_rst = 1'b1; bc_clear = 1'b0; bc_rnum = '0; bc_wen = '0; bc_wnum = '0; bc_wd = '0;

        tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'h0,        32'h0};
        tbl[1] = '{1'b1, 5'd0,  32'h00001234, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
        tbl[2] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
        tbl[3] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd30, 32'h0,        32'h0};
        tbl[4] = '{1'b1, 5'd1,  32'h00000001, 5'd31, 5'd1,  32'hCAFEF00D, 32'h0};
        tbl[5] = '{1'b0, 5'd1,  32'h0,        5'd1,  5'd31, 32'h00000001, 32'hCAFEF00D};
        tbl[6] = '{1'b1, 5'd5,  32'h00005555, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        tbl[7] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'h00005555, 32'h0};

        // Reset held for two edges
        tick();
        tick();
        chk("rst_a_busy", 64'(a_busy), 64'd1);
        chk("rst_a_rd", a_rd, 64'd0);
        chk("rst_b_busy", 64'(b_busy), 64'd1);

        // Release A with a write held on the whole time; it must be ignored
        a_rst = 1'b0;
        a_wen = 1'b1; a_wnum = 5'd3; a_wd = 32'hAA;
        run_clear_a("reset_clear", 31, 0, 0);
        check_all_zero_a("after_reset");

        for (int i = 0; i < 8; i++) begin
            a_wen = tbl[i].wen; a_wnum = tbl[i].wnum; a_wd = tbl[i].wd;
            a_rnum = {tbl[i].r1, tbl[i].r0};
            #1;
            $display("vec %0d: wen=%0d x%0d<=%h rd x%0d=%h x%0d=%h", i, tbl[i].wen, tbl[i].wnum,
                     tbl[i].wd, tbl[i].r0, a_rd[31:0], tbl[i].r1, a_rd[63:32]);
            chk($sformatf("vec%0d_rd0", i), a_rd[31:0], 64'(tbl[i].e0));
            chk($sformatf("vec%0d_rd1", i), a_rd[63:32], 64'(tbl[i].e1));
            tick();
        end

        // Fill x1..x31, then clear with a write in the same cycle and writes/clears during busy
        for (int i = 1; i < 32; i++) begin
            a_wen = 1'b1; a_wnum = 5'(i); a_wd = 32'h1000_0000 + 32'(i * 3 + 1);
            tick();
        end
        a_wen = 1'b0;
        for (int i = 1; i < 32; i++) begin
            a_rnum = {5'(i), 5'(i)};
            #1;
            chk("fill_rd", a_rd[31:0], 64'(32'h1000_0000 + 32'(i * 3 + 1)));
        end
        a_clear = 1'b1; a_wen = 1'b1; a_wnum = 5'd9; a_wd = 32'h77;
        tick();
        a_clear = 1'b0;
        chk("clear_busy_rise", 64'(a_busy), 64'd1);
        a_wnum = 5'd3; a_wd = 32'hAA;
        run_clear_a("clear_req", 31, 5, 10);
        check_all_zero_a("after_clear");

        // Reset when the counter reaches 10
        a_wen = 1'b1; a_wnum = 5'd4; a_wd = 32'h44;
        tick();
        a_wen = 1'b0;
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("mid_busy", 64'(a_busy), 64'd1);
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0;
        chk("mid_rst_busy", 64'(a_busy), 64'd1);
        run_clear_a("mid_reset", 31, 0, 0);
        check_all_zero_a("after_mid_reset");

        // B/C reset: bypass candidates present during clear must not leak
        bc_rst = 1'b0;
        bc_wen = 2'b11; bc_wnum = {4'd6, 4'd6}; bc_wd = {32'h66, 32'h65};
        bc_rnum = {4'd6, 4'd6, 4'd6, 4'd0};
        cycles = 0;
        while ((b_busy === 1'b1 || c_busy === 1'b1) && cycles < 200) begin
            #1;
            chk("bc_clr_b_rd", b_rd, 128'd0);
            chk("bc_clr_c_rd", c_rd, 128'd0);
            chk("bc_clr_busy_eq", 64'(b_busy), 64'(c_busy));
            tick();
            cycles++;
        end
        chk("bc_clear_len", 64'(cycles), 64'd15);
        $display("clear sequence bc_reset: busy for %0d cycles", cycles);

        // Same-index dual write: port 1 must win
        bc_wen = 2'b11; bc_wnum = {4'd7, 4'd7}; bc_wd = {32'h22, 32'h11};
        bc_rnum = {4'd7, 4'd7, 4'd7, 4'd7};
        #1;
        for (int p = 0; p < 4; p++) begin
            chk("bypass_b_same", 64'(b_rd[p*32 +: 32]), 64'h22);
            chk("bypass_c_same", 64'(c_rd[p*32 +: 32]), 64'h0);
        end
        $display("bypass x7: b=%h c=%h", b_rd[31:0], c_rd[31:0]);
        tick();
        bc_wen = 2'b00;
        #1;
        for (int p = 0; p < 4; p++) begin
            chk("bypass_b_next", 64'(b_rd[p*32 +: 32]), 64'h22);
            chk("bypass_c_next", 64'(c_rd[p*32 +: 32]), 64'h22);
        end

        // Randomized traffic against an array model
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[7] = 32'h22;
        busy_left = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            wn0 = 4'($urandom_range(0, 15));
            wn1 = ($urandom_range(0, 3) == 0) ? wn0 : 4'($urandom_range(0, 15));
            bc_wen   = 2'($urandom_range(0, 3));
            bc_wnum  = {wn1, wn0};
            bc_wd    = {$urandom, $urandom};
            bc_clear = ($urandom_range(0, 299) == 0);
            for (int p = 0; p < 4; p++) begin
                s = $urandom_range(0, 5);
                case (s)
                    0:       rn[p] = 4'd0;
                    1:       rn[p] = wn0;
                    2:       rn[p] = wn1;
                    default: rn[p] = 4'($urandom_range(0, 15));
                endcase
            end
            bc_rnum = {rn[3], rn[2], rn[1], rn[0]};
            #1;
            for (int p = 0; p < 4; p++) begin
                exp_c = (busy_left > 0) ? 32'd0 : mem[rn[p]];
                exp_b = exp_c;
                if (busy_left == 0 && rn[p] != 4'd0) begin
                    if (bc_wen[0] && wn0 == rn[p]) exp_b = bc_wd[31:0];
                    if (bc_wen[1] && wn1 == rn[p]) exp_b = bc_wd[63:32];
                end
                chk($sformatf("rand_b_rd%0d_cyc%0d", p, cyc), 64'(b_rd[p*32 +: 32]), 64'(exp_b));
                chk($sformatf("rand_c_rd%0d_cyc%0d", p, cyc), 64'(c_rd[p*32 +: 32]), 64'(exp_c));
            end
            chk($sformatf("rand_b_busy_cyc%0d", cyc), 64'(b_busy), 64'(busy_left > 0));
            chk($sformatf("rand_c_busy_cyc%0d", cyc), 64'(c_busy), 64'(busy_left > 0));
            if (busy_left > 0) begin
                busy_left--;
            end else begin
                if (bc_wen[0] && wn0 != 4'd0) mem[wn0] = bc_wd[31:0];
                if (bc_wen[1] && wn1 != 4'd0) mem[wn1] = bc_wd[63:32];
                if (bc_clear) begin
                    for (int i = 0; i < 16; i++) mem[i] = '0;
                    busy_left = 15;
                end
            end
            tick();
        end
        bc_clear = 1'b0;
        $display("random traffic: 10000 cycles on NRD=4 NWR=2 NREGS=16");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
